// File: rtl/acq_bank_writer_if.sv
// Acquisition bank writer bus: sample input, memory write port and
// readout flags. The writer uses slave, the sample source/reader master.
interface acq_bank_writer_if #(
  parameter int DW = 12
);
  logic          trig;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic [1:0]    bank_release;
  logic          we;
  logic [8:0]    waddr;
  logic [DW-1:0] wdata;
  logic          bank;
  logic          bank0_full;
  logic          bank1_full;
  logic          memorization_completed;
  logic [7:0]    idx_final;
  logic          overrun;

  modport master (
    output trig,
    output sample_valid,
    output sample,
    output bank_release,
    input  we,
    input  waddr,
    input  wdata,
    input  bank,
    input  bank0_full,
    input  bank1_full,
    input  memorization_completed,
    input  idx_final,
    input  overrun
  );

  modport slave (
    input  trig,
    input  sample_valid,
    input  sample,
    input  bank_release,
    output we,
    output waddr,
    output wdata,
    output bank,
    output bank0_full,
    output bank1_full,
    output memorization_completed,
    output idx_final,
    output overrun
  );
endinterface

// File: rtl/acq_bank_writer.sv
// Ping-pong bank writer for one acoustic event: fills two banks,
// raises full/completion flags and refuses to overwrite unread banks.
module acq_bank_writer #(
  parameter int DW        = 12,
  parameter int DEPTH     = 200,
  parameter int HOLDOFF   = 16,
  parameter int FULL_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  acq_bank_writer_if.slave  bus
);
  localparam int FW = $clog2(FULL_HOLD + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          bank_q, bank_d;
  logic [7:0]    idx_q, idx_d;
  logic [1:0]    busy_q, busy_d;
  logic [1:0]    set_b;
  logic          wrap_q, wrap_d;
  logic          ovr_q, ovr_d;
  logic          we_q, we_d;
  logic [8:0]    waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [FW-1:0] f0_q, f0_d;
  logic [FW-1:0] f1_q, f1_d;
  logic          pend_q, pend_d;
  logic          mc_q, mc_d;
  logic [7:0]    idxf_q, idxf_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    set_b   = 2'b00;
    wrap_d  = 1'b0;
    ovr_d   = ovr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    f0_d    = (f0_q != '0) ? f0_q - FW'(1) : '0;
    f1_d    = (f1_q != '0) ? f1_q - FW'(1) : '0;
    pend_d  = 1'b0;
    mc_d    = pend_q;
    idxf_d  = idxf_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.trig) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        if (!bus.trig) begin
          state_d = HOLD;
          hcnt_d  = '0;
          // wrap_q: the bank just filled is the one being completed
          if (wrap_q) begin
            idxf_d = 8'(DEPTH - 1);
            pend_d = 1'b1;
          end else if (idx_q != '0) begin
            idxf_d        = idx_q - 8'd1;
            pend_d        = 1'b1;
            set_b[bank_q] = 1'b1;
            bank_d        = ~bank_q;
            idx_d         = '0;
          end else if (!busy_q[bank_q]) begin
            we_d          = 1'b1;
            waddr_d       = {bank_q, 8'h00};
            wdata_d       = '0;
            idxf_d        = '0;
            pend_d        = 1'b1;
            set_b[bank_q] = 1'b1;
            bank_d        = ~bank_q;
          end
        end else begin
          if (wrap_q) begin
            if (bank_q) f0_d = FW'(FULL_HOLD);
            else        f1_d = FW'(FULL_HOLD);
          end
          if (bus.sample_valid) begin
            if (busy_q[bank_q]) begin
              ovr_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              waddr_d = {bank_q, idx_q};
              wdata_d = bus.sample;
              if (idx_q == 8'(DEPTH - 1)) begin
                set_b[bank_q] = 1'b1;
                bank_d        = ~bank_q;
                idx_d         = '0;
                wrap_d        = 1'b1;
              end else begin
                idx_d = idx_q + 8'd1;
              end
            end
          end
        end
      end
      HOLD: begin
        hcnt_d = hcnt_q + HW'(1);
        if (hcnt_q == HW'(HOLDOFF - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (busy_q & ~bus.bank_release) | set_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= '0;
      wrap_q  <= 1'b0;
      ovr_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      f0_q    <= '0;
      f1_q    <= '0;
      pend_q  <= 1'b0;
      mc_q    <= 1'b0;
      idxf_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      ovr_q   <= ovr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      pend_q  <= pend_d;
      mc_q    <= mc_d;
      idxf_q  <= idxf_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign bus.we                     = we_q;
  assign bus.waddr                  = waddr_q;
  assign bus.wdata                  = wdata_q;
  assign bus.bank                   = bank_q;
  assign bus.bank0_full             = (f0_q != '0);
  assign bus.bank1_full             = (f1_q != '0);
  assign bus.memorization_completed = mc_q;
  assign bus.idx_final              = idxf_q;
  assign bus.overrun                = ovr_q;
endmodule

// File: tb/tb_acq_bank_writer.sv
// Randomised scoreboard bench for acq_bank_writer against an
// event-level model of the two-bank acquisition rules.
module tb_acq_bank_writer;
  localparam int DW        = 12;
  localparam int DEPTH     = 200;
  localparam int HOLDOFF   = 16;
  localparam int FULL_HOLD = 2;

  typedef struct {
    logic [8:0]    addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;
  typedef struct {
    logic [7:0] idx;
    int         cyc;
  } cp_t;
  typedef struct {
    bit b;
    int cyc;
  } fl_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  acq_bank_writer_if #(.DW(DW)) bus ();

  acq_bank_writer #(
    .DW(DW),
    .DEPTH(DEPTH),
    .HOLDOFF(HOLDOFF),
    .FULL_HOLD(FULL_HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  wr_t wq[$];
  cp_t cq[$];
  fl_t fq[$];

  // model state: 0 idle, 1 event active, 2 dead time
  int       m_st;
  bit       m_bank;
  bit       m_filled;
  bit       m_ovr;
  int       m_cnt;
  int       m_dead;
  bit [1:0] m_busy;
  int       rel_cd[2];
  bit       auto_rel = 1'b1;
  int       rel_max  = 5;

  function automatic void model_reset();
    m_st = 0; m_bank = 0; m_filled = 0; m_ovr = 0;
    m_cnt = 0; m_dead = 0; m_busy = 2'b00;
    rel_cd[0] = -1; rel_cd[1] = -1;
  endfunction

  function automatic void push_wr(logic [8:0] a, logic [DW-1:0] d, int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    wq.push_back(w);
  endfunction

  function automatic void push_cp(int idx, int c);
    cp_t p;
    p.idx = 8'(idx); p.cyc = c;
    cq.push_back(p);
  endfunction

  function automatic void push_fl(bit b, int c);
    fl_t f;
    f.b = b; f.cyc = c;
    fq.push_back(f);
  endfunction

  function automatic void sched(bit b);
    if (auto_rel) rel_cd[b] = $urandom_range(1, rel_max);
  endfunction

  // inputs driven now are sampled at the next rising edge
  function automatic void model_step(bit trig, bit sv,
                                     logic [DW-1:0] s, bit [1:0] rel);
    bit [1:0] set = 2'b00;
    bit filled_now = 1'b0;
    case (m_st)
      0: if (trig) begin m_st = 1; m_cnt = 0; end
      1: begin
        if (!trig) begin
          m_st = 2; m_dead = HOLDOFF;
          if (m_filled) begin
            push_cp(DEPTH - 1, cyc + 2);
            sched(!m_bank);
          end else if (m_cnt > 0) begin
            push_cp(m_cnt - 1, cyc + 2);
            sched(m_bank);
            set[m_bank] = 1; m_bank = !m_bank;
          end else if (!m_busy[m_bank]) begin
            push_wr({m_bank, 8'h00}, '0, cyc + 1);
            push_cp(0, cyc + 2);
            sched(m_bank);
            set[m_bank] = 1; m_bank = !m_bank;
          end
        end else begin
          if (m_filled) begin
            push_fl(!m_bank, cyc + 1);
            sched(!m_bank);
          end
          if (sv) begin
            if (m_busy[m_bank]) m_ovr = 1;
            else begin
              push_wr({m_bank, 8'(m_cnt)}, s, cyc + 1);
              m_cnt++;
              if (m_cnt == DEPTH) begin
                set[m_bank] = 1; m_bank = !m_bank;
                m_cnt = 0; filled_now = 1;
              end
            end
          end
        end
      end
      default: begin
        m_dead--;
        if (m_dead == 0) m_st = 0;
      end
    endcase
    m_filled = filled_now;
    m_busy = (m_busy & ~rel) | set;
  endfunction

  task automatic drive(input bit trig, input bit sv,
                       input bit [1:0] rel_force = 2'b00);
    logic [DW-1:0] s;
    bit [1:0] rel;
    s = DW'($urandom);
    rel = rel_force;
    @(negedge clk);
    check("bank", bus.bank, m_bank);
    check("overrun", bus.overrun, m_ovr);
    for (int i = 0; i < 2; i++) begin
      if (rel_cd[i] == 0) rel[i] = 1'b1;
      if (rel_cd[i] >= 0) rel_cd[i]--;
    end
    bus.trig = trig;
    bus.sample_valid = sv;
    bus.sample = s;
    bus.bank_release = rel;
    model_step(trig, sv, s, rel);
  endtask

  task automatic run_event(input int n, input bit gaps,
                           input int tail, input int post);
    int sent;
    bit v;
    sent = 0;
    drive(1, 0);
    while (sent < n) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(1, v);
      if (v) sent++;
    end
    repeat (tail) drive(1, 0);
    drive(0, 1'($urandom_range(0, 1)));
    repeat (post) drive(0, 0);
  endtask

  task automatic hit_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_outputs",
          {bus.we, bus.waddr, bus.wdata, bus.bank,
           bus.bank0_full, bus.bank1_full,
           bus.memorization_completed, bus.idx_final,
           bus.overrun}, '0);
    check("rst_pending_writes", wq.size(), 0);
    wq.delete(); cq.delete(); fq.delete();
    model_reset();
    bus.trig = 0; bus.sample_valid = 0;
    bus.sample = '0; bus.bank_release = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // monitor
  bit         mc_prev;
  logic [7:0] idxf_prev;
  int         fh[2];
  bit         fprev[2];

  always @(negedge clk) begin
    if (!reset) begin
      mc_prev = 0; fh[0] = 0; fh[1] = 0;
      fprev[0] = 0; fprev[1] = 0;
    end else begin
      if (bus.we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_unexpected: got addr %0h expected none",
                   bus.waddr);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("waddr", bus.waddr, w.addr);
          check("wdata", bus.wdata, w.data);
          check("write_cycle", cyc, w.cyc);
        end
      end
      if (bus.memorization_completed) begin
        check("completion_width", mc_prev, 0);
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL completion_unexpected: got idx %0d expected none",
                   bus.idx_final);
        end else begin
          cp_t p;
          p = cq.pop_front();
          check("idx_final", bus.idx_final, p.idx);
          check("idx_final_early", idxf_prev, p.idx);
          check("completion_cycle", cyc, p.cyc);
        end
      end
      for (int b = 0; b < 2; b++) begin
        bit f;
        f = (b == 0) ? bus.bank0_full : bus.bank1_full;
        if (f && !fprev[b]) begin
          if (fq.size() == 0) begin
            checks++; errors++;
            $display("FAIL full_unexpected: got bank %0d expected none", b);
          end else begin
            fl_t e;
            e = fq.pop_front();
            check("full_bank", b, e.b);
            check("full_cycle", cyc, e.cyc);
          end
        end
        if (f) fh[b]++;
        if (!f && fprev[b]) begin
          check("full_len", fh[b], FULL_HOLD);
          fh[b] = 0;
        end
        fprev[b] = f;
      end
      mc_prev = bus.memorization_completed;
      idxf_prev = bus.idx_final;
    end
  end

  initial begin
    bus.trig = 0; bus.sample_valid = 0;
    bus.sample = '0; bus.bank_release = 2'b00;
    model_reset();
    @(negedge clk);
    hit_reset();

    // short event
    run_event(50, 0, 0, HOLDOFF + 4);
    check("short_bank_after", bus.bank, 1);
    // long event with releases
    run_event(450, 1, 0, HOLDOFF + 4);
    // trig falls with the last word of a bank
    run_event(200, 0, 0, HOLDOFF + 4);
    // trig falls right after the full toggle
    run_event(200, 0, 1, HOLDOFF + 4);

    // overrun with no releases
    auto_rel = 0;
    drive(0, 0, 2'b11);
    drive(1, 0);
    repeat (600) drive(1, 1);
    drive(1, 0);
    check("overrun_sticky", bus.overrun, 1);
    drive(1, 0, m_bank ? 2'b10 : 2'b01);
    repeat (20) drive(1, 1);
    drive(0, 0);
    repeat (HOLDOFF + 4) drive(0, 0);
    drive(0, 0, 2'b11);
    auto_rel = 1;

    // reset in the middle of writing
    drive(1, 0);
    repeat (30) drive(1, 1);
    drive(1, 0);
    hit_reset();
    check("overrun_cleared", bus.overrun, 0);

    // trigger during dead time is ignored
    drive(1, 0);
    repeat (10) drive(1, 1);
    drive(0, 0);
    repeat (3) drive(0, 0);
    repeat (3) drive(1, 1);
    repeat (HOLDOFF + 4) drive(0, 0);

    // randomised events
    for (int k = 0; k < 12; k++) begin
      rel_max = $urandom_range(1, 40);
      run_event($urandom_range(1, 500), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3),
                $urandom_range(HOLDOFF - 3, HOLDOFF + 3));
    end

    repeat (HOLDOFF + 10) drive(0, 0);
    check("writes_drained", wq.size(), 0);
    check("completions_drained", cq.size(), 0);
    check("fulls_drained", fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
